wakeup_sched: RTL and testbench
===============================

Name: wakeup_sched

Overview:
- Downstream companion of the issue queues: takes the destination tags of the ops issued each cycle and replays each tag on a writeback/wakeup lane after that op's fixed execution latency.
- The 4-lane output is the i_wdest4x wakeup bus that the issue slots compare against.
- Each lane owns a latency-indexed shift register ("timing wheel"). It enforces one broadcast per lane per cycle by back-pressuring conflicting issues.
- Entries are squashed on branch kill.

Parameters:
- WIDTH_REG, 5, physical register tag width.
- WIDTH_BRM, 3, branch mask width (same encoding as i_BrKill).
- DEPTH, 4, maximum supported execution latency in cycles; wheel slots per lane.
- WIDTH_LAT, 3, width of each latency field; must satisfy 2^WIDTH_LAT > DEPTH.

Ports:
- i_clk, input, 1, clock, rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_valid4x, input, 4, per-lane issue valid.
- i_dest4x, input, 4*WIDTH_REG, per-lane destination tag; lane l occupies bits [l*WIDTH_REG +: WIDTH_REG].
- i_lat4x, input, 4*WIDTH_LAT, per-lane execution latency.
- i_brmask4x, input, 4*WIDTH_BRM, per-lane branch dependency mask of the issued op.
- i_BrKill, input, WIDTH_BRM, branches resolved as mispredicted this cycle.
- o_wdest4x, output, 4*WIDTH_REG, per-lane wakeup tag; 0 = no wakeup.
- o_stall4x, output, 4, per-lane combinational "issue not accepted, hold".

Behaviour:
- Entry format: {v, dest[WIDTH_REG], brmask[WIDTH_BRM]}. Each lane holds slot[0..DEPTH-1].
- Reset (async, i_rst_n=0): every v clears. o_wdest4x=0 and o_stall4x=0 while in reset and in the first cycle after release.
- Output: o_wdest4x lane l = slot[0].v ? slot[0].dest : 0. Driven straight from flops; no combinational path from inputs.
- Effective latency L: i_lat=0 is treated as 1; i_lat>DEPTH is clamped to DEPTH.
- Accept condition for lane l: i_valid4x[l] & (dest != 0) & ~conflict. Dest 0 never schedules and never stalls.
- Conflict (combinational): L<DEPTH and pre-shift slot[L].v=1 and that entry is not killed this cycle. Then o_stall4x[l]=1, nothing is written, and upstream must hold the op.
- L=DEPTH never conflicts.
- o_stall4x[l]=0 whenever i_valid4x[l]=0.
- Each rising edge:
  - slot[k] <= slot[k+1] for k<DEPTH-1; slot[DEPTH-1] <= empty.
  - Then, if accepted, slot[L-1] <= {1, dest, brmask}.
  - Net result: tag issued at edge t appears on o_wdest4x from edge t+L-1, i.e. visible in cycle t+L, for exactly one cycle.
- Branch kill, applied at the same edge as the shift:
  - Any entry with (brmask & i_BrKill)!=0 is written with v=0, including an accepted incoming op.
  - An entry moving into slot[0] on a kill edge is squashed, so output 0.
- Simultaneous issues on different lanes are independent. There is no cross-lane ordering or arbitration.
- With i_BrKill=0, entries are never lost or duplicated.
- Reset mid-operation discards all in-flight entries immediately.

Test Plan:
- Reset / idle: assert i_rst_n=0 with the wheels partly full, then release -> o_wdest4x=0 for every cycle until a new issue.
- Basic latency, default params: issue lane0 dest=7 L=1 at edge t -> o_wdest4x[4:0]=7 in cycle t+1 only. Issue lane2 dest=9 L=3 -> lane2=9 only in cycle t+3.
- Conflict: lane1 issues dest=5 L=3 at t, then dest=6 L=2 at t+1 -> o_stall4x[1]=1 in cycle t+1, dest 5 broadcast at t+3. Retry at t+2 is accepted and 6 broadcasts at t+4.
- Kill:
  - lane3 dest=12 brmask=3'b010 L=4 at t; i_BrKill=3'b010 at t+2 -> lane3 stays 0 through t+5.
  - Same with i_BrKill=3'b001 -> 12 appears at t+4.
- Kill on issue plus dest 0: issue with brmask & i_BrKill != 0 -> not broadcast, no stall. Issue of dest=0 -> no stall, no broadcast, does not block a later conflicting latency.
- Clamp / concurrency: all four lanes issue in the same cycle with L=0, 1, 4 and 7 -> broadcasts at +1, +1, +4 and +4 respectively, no stalls.

Source files
------------

// File: rtl/wakeup_sched.sv
// Wakeup scheduler: per-lane timing wheels that replay issued destination tags
// after each op's execution latency, with conflict back-pressure and branch kill.
module wakeup_sched #(
  parameter int unsigned WIDTH_REG = 5,
  parameter int unsigned WIDTH_BRM = 3,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WIDTH_LAT = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [3:0]               i_valid4x,
  input  logic [4*WIDTH_REG-1:0]   i_dest4x,
  input  logic [4*WIDTH_LAT-1:0]   i_lat4x,
  input  logic [4*WIDTH_BRM-1:0]   i_brmask4x,
  input  logic [WIDTH_BRM-1:0]     i_BrKill,
  output logic [4*WIDTH_REG-1:0]   o_wdest4x,
  output logic [3:0]               o_stall4x
);

  localparam int unsigned NLANE = 4;

  typedef struct packed {
    logic                 v;
    logic [WIDTH_REG-1:0] dest;
    logic [WIDTH_BRM-1:0] brm;
  } entry_t;

  entry_t               slot_q  [NLANE][DEPTH];
  entry_t               slot_d  [NLANE][DEPTH];
  logic [WIDTH_REG-1:0] wdest_q [NLANE];
  logic [WIDTH_LAT-1:0] lat_eff [NLANE];
  logic [WIDTH_REG-1:0] dest_in [NLANE];
  logic [WIDTH_BRM-1:0] brm_in  [NLANE];
  logic [NLANE-1:0]     conflict;
  logic [NLANE-1:0]     accept;

  // Lane decode, latency clamp and conflict against the pre-shift wheel
  always_comb begin
    conflict  = '0;
    accept    = '0;
    o_stall4x = '0;
    for (int l = 0; l < int'(NLANE); l++) begin
      dest_in[l] = i_dest4x[l*WIDTH_REG +: WIDTH_REG];
      brm_in[l]  = i_brmask4x[l*WIDTH_BRM +: WIDTH_BRM];
      lat_eff[l] = i_lat4x[l*WIDTH_LAT +: WIDTH_LAT];
      if (lat_eff[l] == '0)
        lat_eff[l] = WIDTH_LAT'(1);
      else if (lat_eff[l] > WIDTH_LAT'(DEPTH))
        lat_eff[l] = WIDTH_LAT'(DEPTH);
      // slot[L] lands in slot[L-1] after the shift; an entry dying this edge frees it
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (lat_eff[l] == WIDTH_LAT'(k) && slot_q[l][k].v &&
            (slot_q[l][k].brm & i_BrKill) == '0)
          conflict[l] = 1'b1;
      end
      accept[l]    = i_valid4x[l] && (dest_in[l] != '0) && !conflict[l];
      o_stall4x[l] = i_valid4x[l] && (dest_in[l] != '0) && conflict[l];
    end
  end

  // Next wheel contents: shift, squash killed entries, insert accepted issue
  always_comb begin
    for (int l = 0; l < int'(NLANE); l++) begin
      for (int k = 0; k < int'(DEPTH); k++)
        slot_d[l][k] = '0;
      for (int k = 0; k < int'(DEPTH) - 1; k++)
        slot_d[l][k] = slot_q[l][k+1];
      for (int k = 0; k < int'(DEPTH); k++) begin
        if ((slot_d[l][k].brm & i_BrKill) != '0)
          slot_d[l][k].v = 1'b0;
        if (accept[l] && lat_eff[l] == WIDTH_LAT'(k + 1)) begin
          slot_d[l][k].v    = ((brm_in[l] & i_BrKill) == '0);
          slot_d[l][k].dest = dest_in[l];
          slot_d[l][k].brm  = brm_in[l];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int l = 0; l < int'(NLANE); l++) begin
        wdest_q[l] <= '0;
        for (int k = 0; k < int'(DEPTH); k++)
          slot_q[l][k] <= '0;
      end
    end else begin
      for (int l = 0; l < int'(NLANE); l++) begin
        wdest_q[l] <= slot_d[l][0].v ? slot_d[l][0].dest : '0;
        for (int k = 0; k < int'(DEPTH); k++)
          slot_q[l][k] <= slot_d[l][k];
      end
    end
  end

  always_comb begin
    o_wdest4x = '0;
    for (int l = 0; l < int'(NLANE); l++)
      o_wdest4x[l*WIDTH_REG +: WIDTH_REG] = wdest_q[l];
  end

endmodule

// File: tb/tb_wakeup_sched.sv
// Directed bench for wakeup_sched: expected wakeups are queued at issue time
// and retired against o_wdest4x on the cycle they fall due.
module tb_wakeup_sched;

  localparam int unsigned WR = 5;
  localparam int unsigned WB = 3;
  localparam int unsigned WL = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      valid;
  logic [4*WR-1:0] dest;
  logic [4*WL-1:0] lat;
  logic [4*WB-1:0] brm;
  logic [WB-1:0]   kill;
  logic [4*WR-1:0] wdest;
  logic [3:0]      stall;

  typedef struct {
    int          due;
    int          lane;
    logic [WR-1:0] dest;
  } exp_t;

  exp_t sb[$];
  int   cyc  = 0;
  int   ncmp = 0;
  int   nerr = 0;

  wakeup_sched dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid4x  (valid),
    .i_dest4x   (dest),
    .i_lat4x    (lat),
    .i_brmask4x (brm),
    .i_BrKill   (kill),
    .o_wdest4x  (wdest),
    .o_stall4x  (stall)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clr();
    valid = '0; dest = '0; lat = '0; brm = '0; kill = '0;
  endtask

  // Drive one lane; when ok, queue the wakeup due after the clamped latency
  task automatic issue(input int l, input int d, input int lt, input int b, input bit ok);
    int le;
    le = (lt == 0) ? 1 : (lt > 4) ? 4 : lt;
    valid[l]           = 1'b1;
    dest[l*WR +: WR]   = WR'(d);
    lat[l*WL +: WL]    = WL'(lt);
    brm[l*WB +: WB]    = WB'(b);
    if (ok) sb.push_back('{cyc + le, l, WR'(d)});
  endtask

  task automatic check_lanes();
    for (int l = 0; l < 4; l++) begin
      logic [WR-1:0] e;
      e = '0;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].due == cyc && sb[i].lane == l) begin
          e = sb[i].dest;
          sb.delete(i);
          break;
        end
      end
      cmp($sformatf("wdest_l%0d_c%0d", l, cyc), 32'(wdest[l*WR +: WR]), 32'(e));
    end
  endtask

  task automatic tick(input logic [3:0] es);
    #1;
    cmp($sformatf("stall_c%0d", cyc), 32'(stall), 32'(es));
    @(posedge clk);
    #1;
    cyc++;
    check_lanes();
    clr();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(4'b0000);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_wdest", 32'(wdest), 32'd0);
    cmp("reset_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // basic latency
    issue(0, 7, 1, 0, 1);
    tick(4'b0000);
    idle(2);
    issue(2, 9, 3, 0, 1);
    tick(4'b0000);
    idle(4);

    // conflict and retry
    issue(1, 5, 3, 0, 1);
    tick(4'b0000);
    issue(1, 6, 2, 0, 0);
    tick(4'b0010);
    issue(1, 6, 2, 0, 1);
    tick(4'b0000);
    idle(4);

    // kill hits in flight
    issue(3, 12, 4, 3'b010, 0);
    tick(4'b0000);
    tick(4'b0000);
    kill = 3'b010;
    tick(4'b0000);
    idle(4);

    // kill misses
    issue(3, 12, 4, 3'b010, 1);
    tick(4'b0000);
    tick(4'b0000);
    kill = 3'b001;
    tick(4'b0000);
    idle(4);

    // kill on issue, then dest 0 leaves no footprint
    issue(0, 3, 2, 3'b100, 0);
    kill = 3'b100;
    tick(4'b0000);
    issue(1, 0, 3, 0, 0);
    tick(4'b0000);
    issue(1, 8, 2, 0, 1);
    tick(4'b0000);
    idle(4);

    // an entry dying on this edge does not block a new issue
    issue(2, 10, 3, 3'b001, 0);
    tick(4'b0000);
    issue(2, 11, 2, 0, 1);
    kill = 3'b001;
    tick(4'b0000);
    idle(4);

    // clamp and concurrency; latency DEPTH never conflicts
    issue(0, 1, 0, 0, 1);
    issue(1, 2, 1, 0, 1);
    issue(2, 3, 4, 0, 1);
    issue(3, 4, 7, 0, 1);
    tick(4'b0000);
    issue(2, 13, 4, 0, 1);
    tick(4'b0000);
    idle(5);

    // reset mid-operation discards in-flight entries
    issue(0, 20, 4, 0, 0);
    issue(1, 21, 4, 0, 0);
    issue(2, 22, 3, 0, 0);
    issue(3, 23, 2, 0, 0);
    tick(4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("midreset_wdest", 32'(wdest), 32'd0);
    issue(0, 5, 2, 0, 0);
    #1;
    cmp("midreset_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    cyc++;
    cmp("midreset_hold_wdest", 32'(wdest), 32'd0);
    clr();
    rst_n = 1'b1;
    idle(6);

    cmp("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
